hlpte_protocol_monitor: RTL and testbench
=========================================

// Module: hlpte_protocol_monitor
// PURPOSE
//  Synthesizable, parametrised monitor for the HLPTE I/O protocol.
//  - Sequence checked: frame load burst, then per set a param burst followed by an output burst.
//  - Sits beside the DUT in bench and FPGA-proto builds; observes valids only, never drives DUT.
//  - Reports the first protocol violation, per-set latency, set count and accumulated latency.
// PARAMETERS
//  DATA_BEATS   16384  in_valid_data beats per pattern (frames*pixels)
//  PARAM_BEATS  4      in_valid_param beats per set
//  OUT_LEN      1024   out_valid beats per set
//  SET_NUM      16     sets per pattern
//  GAP_MIN      2      min idle cycles before each param burst
//  GAP_MAX      4      max idle cycles before each param burst
//  MAX_LAT      10000  max cycles from param end to first out_valid
//  TOT_W        32     width of total_latency
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       synchronous active-low reset
//  in_valid_data   in   1       DUT frame-data valid
//  in_valid_param  in   1       DUT param valid
//  out_valid       in   1       DUT output valid
//  out_value       in   32      DUT output value, signed
//  err_flag        out  1       sticky: violation detected
//  err_code        out  4       first violation code, 0 = none
//  set_done        out  1       1-cycle pulse after last out beat of a set
//  set_latency     out  clog2(MAX_LAT+1)  latency of last completed set
//  set_cnt         out  clog2(SET_NUM+1)  sets completed in current pattern
//  pat_cnt         out  16      patterns completed, wraps at 2^16
//  total_latency   out  TOT_W   sum of set_latency, saturates at all-ones
// BEHAVIOUR
//  Reset:
//  - Synchronous active-low reset on clk only; all outputs and counters reset to 0, FSM to IDLE.
//  - Reset asserted mid-operation aborts the current sequence; err_flag clears.
//  FSM states and transitions:
//  - IDLE: in_valid_data=1 -> LOAD with beat count = 1.
//  - LOAD: counts data beats.
//      * Data valid falls with count != DATA_BEATS: err 1.
//      * Data valid falls with count == DATA_BEATS: -> GAP.
//  - GAP: counts idle cycles since previous burst end.
//      * in_valid_param rises with gap < GAP_MIN: err 2.
//      * Gap reaches GAP_MAX+1 with no param: err 3.
//      * Otherwise -> PARAM.
//  - PARAM: counts param beats.
//      * Param valid falls with count != PARAM_BEATS: err 4.
//      * Count == PARAM_BEATS: -> WAIT; latency counter = 0.
//  - WAIT: latency counter increments each cycle out_valid=0.
//      * in_valid_param=1: err 5.
//      * Counter reaches MAX_LAT with out_valid still 0: err 6.
//      * out_valid=1: -> OUT, out beat count = 1; set_latency latched.
//  - OUT: counts out beats.
//      * out_valid falls before OUT_LEN beats: err 7.
//      * out_valid still 1 on beat OUT_LEN+1: err 8.
//      * Any in_valid_param while out_valid: err 5.
//      * After exactly OUT_LEN beats: set_done pulses the next cycle; set_cnt++.
//      * total_latency += set_latency, saturating.
//      * If set_cnt hits SET_NUM: set_cnt->0, pat_cnt++, -> IDLE. Else -> GAP.
//  - ERR: entered on any violation; sticky until reset.
//      * err_code holds first code; later events ignored.
//  Global violations:
//  - out_valid=1 in IDLE/LOAD/GAP/PARAM: err 9.
//  - in_valid_data=1 outside IDLE/LOAD: err 10.
//  - Multiple violations in one cycle: lowest code recorded.
//  Latency and flags:
//  - err_flag/err_code are registered; they assert the cycle after the violating sample.
//  - X/Z on any valid input counts as 0; no X-propagation into state.
// CONFIGURATION
//  - HLPTE_MON_CHECKSUM_EN defined: adds output port out_sum (32 bits).
//      * Wrapping sum of out_value over the set; cleared at OUT entry.
//      * Holds the final value from set_done until the next OUT entry.
//  - Undefined: port and adder absent; all other behaviour identical.
// TESTING
//  - DATA_BEATS=8, PARAM=4, OUT=4, SET=2, gap 3, lat 5: set_latency=5, total=10, pat_cnt=1, err 0.
//  - Data burst of 7 beats -> err_flag=1, err_code=1 one cycle after valid falls.
//  - Param rising 1 cycle after data falls (GAP_MIN=2) -> err_code=2.
//  - in_valid_param during WAIT -> err 5; MAX_LAT=20 with no out_valid -> err 6 at cycle 20.
//  - out_valid 3 beats (OUT_LEN=4) -> err 7; 5 beats -> err 8; checksum of 1,2,3,-4 = 2.
//  - rst_n=0 for 1 cycle during OUT -> all outputs 0; new full sequence then passes cleanly.

Source files
------------

// File: rtl/hlpte_protocol_monitor.sv
`default_nettype none
// hlpte_protocol_monitor: passive checker of HLPTE valid sequencing (frame load, then param/out per set).
// Defining HLPTE_MON_CHECKSUM_EN adds the out_sum checksum port. Rev 1.0.
module hlpte_protocol_monitor #(
    parameter int DATA_BEATS  = 16384,
    parameter int PARAM_BEATS = 4,
    parameter int OUT_LEN     = 1024,
    parameter int SET_NUM     = 16,
    parameter int GAP_MIN     = 2,
    parameter int GAP_MAX     = 4,
    parameter int MAX_LAT     = 10000,
    parameter int TOT_W       = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid_data,
    input  logic                               in_valid_param,
    input  logic                               out_valid,
    input  logic [31:0]                        out_value,
    output logic                               err_flag,
    output logic [3:0]                         err_code,
    output logic                               set_done,
    output logic [$clog2(MAX_LAT+1)-1:0]       set_latency,
    output logic [$clog2(SET_NUM+1)-1:0]       set_cnt,
    output logic [15:0]                        pat_cnt,
`ifdef HLPTE_MON_CHECKSUM_EN
    output logic [31:0]                        out_sum,
`endif
    output logic [TOT_W-1:0]                   total_latency
);

    localparam int LAT_W  = $clog2(MAX_LAT+1);
    localparam int SC_W   = $clog2(SET_NUM+1);
    localparam int MAXB_A = (DATA_BEATS > PARAM_BEATS) ? DATA_BEATS : PARAM_BEATS;
    localparam int MAXB   = (MAXB_A > OUT_LEN) ? MAXB_A : OUT_LEN;
    localparam int BEAT_W = $clog2(MAXB+2);
    localparam int GAP_W  = $clog2(GAP_MAX+2);

    localparam logic [BEAT_W-1:0] DATA_B   = BEAT_W'(DATA_BEATS);
    localparam logic [BEAT_W-1:0] DATA_SAT = BEAT_W'(DATA_BEATS+1);
    localparam logic [BEAT_W-1:0] PARAM_B  = BEAT_W'(PARAM_BEATS);
    localparam logic [BEAT_W-1:0] OUT_B    = BEAT_W'(OUT_LEN);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LO   = GAP_W'(GAP_MIN);
    localparam logic [GAP_W-1:0]  GAP_HI   = GAP_W'(GAP_MAX);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MAX_LAT-1);
    localparam logic [SC_W-1:0]   SET_LAST = SC_W'(SET_NUM-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_PARAM = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t             state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [3:0]         code;
    logic [TOT_W:0]     tot_sum;

    // Anything other than a clean 1 (including X/Z) is treated as deasserted.
    logic dv, pv, ov;
    assign dv = (in_valid_data  === 1'b1);
    assign pv = (in_valid_param === 1'b1);
    assign ov = (out_valid      === 1'b1);

    assign tot_sum = {1'b0, total_latency} + (TOT_W+1)'(set_latency);

    // Checks are ordered so the lowest applicable code wins.
    always_comb begin
        code = 4'd0;
        case (state)
            S_LOAD:  if (!dv && beat_cnt != DATA_B) code = 4'd1;
                     else if (!dv && pv)            code = 4'd2;
            S_GAP:   if (pv && gap_cnt < GAP_LO)    code = 4'd2;
                     else if (!pv && gap_cnt == GAP_HI) code = 4'd3;
            S_PARAM: if (!pv)                       code = 4'd4;
            S_WAIT:  if (pv)                        code = 4'd5;
                     else if (!ov && lat_cnt == LAT_LAST) code = 4'd6;
            S_OUT:   if (pv)                        code = 4'd5;
                     else if (!ov && beat_cnt != OUT_B) code = 4'd7;
                     else if (ov && beat_cnt == OUT_B)  code = 4'd8;
            default: code = 4'd0;
        endcase
        if (code == 4'd0 && ov &&
            (state == S_IDLE || state == S_LOAD || state == S_GAP || state == S_PARAM))
            code = 4'd9;
        if (code == 4'd0 && dv &&
            (state == S_GAP || state == S_PARAM || state == S_WAIT || state == S_OUT))
            code = 4'd10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            lat_cnt       <= '0;
            err_flag      <= 1'b0;
            err_code      <= 4'd0;
            set_done      <= 1'b0;
            set_latency   <= '0;
            set_cnt       <= '0;
            pat_cnt       <= 16'd0;
            total_latency <= '0;
`ifdef HLPTE_MON_CHECKSUM_EN
            out_sum       <= 32'd0;
`endif
        end else begin
            set_done <= 1'b0;
            if (code != 4'd0) begin
                state    <= S_ERR;
                err_flag <= 1'b1;
                err_code <= code;
            end else begin
                case (state)
                    S_IDLE: if (dv) begin
                        state    <= S_LOAD;
                        beat_cnt <= BEAT_ONE;
                    end
                    S_LOAD: if (dv) begin
                        if (beat_cnt != DATA_SAT) beat_cnt <= beat_cnt + BEAT_ONE;
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_W'(1);
                    end
                    S_GAP: if (pv) begin
                        if (PARAM_BEATS == 1) begin
                            state   <= S_WAIT;
                            lat_cnt <= '0;
                        end else begin
                            state    <= S_PARAM;
                            beat_cnt <= BEAT_ONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                    S_PARAM: if (beat_cnt + BEAT_ONE == PARAM_B) begin
                        state   <= S_WAIT;
                        lat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_ONE;
                    end
                    S_WAIT: if (ov) begin
                        state       <= S_OUT;
                        beat_cnt    <= BEAT_ONE;
                        set_latency <= lat_cnt;
`ifdef HLPTE_MON_CHECKSUM_EN
                        out_sum     <= out_value;
`endif
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                    S_OUT: if (ov) begin
                        beat_cnt <= beat_cnt + BEAT_ONE;
`ifdef HLPTE_MON_CHECKSUM_EN
                        out_sum  <= out_sum + out_value;
`endif
                    end else begin
                        // Set completes on the first idle sample after exactly OUT_LEN beats.
                        set_done      <= 1'b1;
                        total_latency <= tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];
                        if (set_cnt == SET_LAST) begin
                            set_cnt <= '0;
                            pat_cnt <= pat_cnt + 16'd1;
                            state   <= S_IDLE;
                        end else begin
                            set_cnt <= set_cnt + SC_W'(1);
                            state   <= S_GAP;
                            gap_cnt <= GAP_W'(1);
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

`ifndef HLPTE_MON_CHECKSUM_EN
    logic unused_out_value;
    assign unused_out_value = ^out_value;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hlpte_protocol_monitor.sv
`default_nettype none
// tb_hlpte_protocol_monitor: directed self-checking bench for hlpte_protocol_monitor. Rev 1.0.
module tb_hlpte_protocol_monitor;

    localparam int DATA_BEATS  = 8;
    localparam int PARAM_BEATS = 4;
    localparam int OUT_LEN     = 4;
    localparam int SET_NUM     = 2;
    localparam int GAP_MIN     = 2;
    localparam int GAP_MAX     = 4;
    localparam int MAX_LAT     = 20;
    localparam int TOT_W       = 32;

    logic        clk;
    logic        rst_n;
    logic        in_valid_data;
    logic        in_valid_param;
    logic        out_valid;
    logic [31:0] out_value;
    logic        err_flag;
    logic [3:0]  err_code;
    logic        set_done;
    logic [4:0]  set_latency;
    logic [1:0]  set_cnt;
    logic [15:0] pat_cnt;
    logic [31:0] total_latency;
`ifdef HLPTE_MON_CHECKSUM_EN
    logic [31:0] out_sum;
`endif

    int checks;
    int passed;

    hlpte_protocol_monitor #(
        .DATA_BEATS(DATA_BEATS), .PARAM_BEATS(PARAM_BEATS), .OUT_LEN(OUT_LEN),
        .SET_NUM(SET_NUM), .GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX),
        .MAX_LAT(MAX_LAT), .TOT_W(TOT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_data(in_valid_data), .in_valid_param(in_valid_param),
        .out_valid(out_valid), .out_value(out_value),
        .err_flag(err_flag), .err_code(err_code), .set_done(set_done),
        .set_latency(set_latency), .set_cnt(set_cnt), .pat_cnt(pat_cnt),
`ifdef HLPTE_MON_CHECKSUM_EN
        .out_sum(out_sum),
`endif
        .total_latency(total_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are applied 1 time unit after an edge, sampled at the next edge, outputs read 1 unit after it.
    task automatic step(input logic dv, input logic pv, input logic ov, input logic [31:0] val);
        in_valid_data  = dv;
        in_valid_param = pv;
        out_valid      = ov;
        out_value      = val;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic burst_data(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic burst_param(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (err_flag !== 1'b0) $display("FAIL reset_err_flag got %0b want 0", err_flag); else passed++;
        checks++; if (err_code !== 4'd0) $display("FAIL reset_err_code got %0d want 0", err_code); else passed++;
        checks++; if (set_done !== 1'b0 || set_cnt !== 2'd0 || pat_cnt !== 16'd0)
            $display("FAIL reset_counters got done=%0b set=%0d pat=%0d want 0/0/0", set_done, set_cnt, pat_cnt); else passed++;
        checks++; if (set_latency !== 5'd0 || total_latency !== 32'd0)
            $display("FAIL reset_latency got lat=%0d tot=%0d want 0/0", set_latency, total_latency); else passed++;
        rst_n = 1'b1;
    endtask

    // Two full sets: gap 3, latency 5, out values 1,2,3,-4 then 5,6,7,8.
    task automatic run_pattern(input string tag);
        burst_data(DATA_BEATS);
        idle(3);
        burst_param(PARAM_BEATS);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 32'd1);
        checks++; if (set_latency !== 5'd5) $display("FAIL %s set_latency got %0d want 5", tag, set_latency); else passed++;
        step(1'b0, 1'b0, 1'b1, 32'd2);
        step(1'b0, 1'b0, 1'b1, 32'd3);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checks++; if (set_done !== 1'b0) $display("FAIL %s set_done_early got %0b want 0", tag, set_done); else passed++;
        idle(1);
        checks++; if (set_done !== 1'b1) $display("FAIL %s set_done1 got %0b want 1", tag, set_done); else passed++;
        checks++; if (set_cnt !== 2'd1) $display("FAIL %s set_cnt1 got %0d want 1", tag, set_cnt); else passed++;
        checks++; if (total_latency !== 32'd5) $display("FAIL %s total1 got %0d want 5", tag, total_latency); else passed++;
`ifdef HLPTE_MON_CHECKSUM_EN
        checks++; if (out_sum !== 32'd2) $display("FAIL %s out_sum1 got %0d want 2", tag, out_sum); else passed++;
`endif
        idle(1);
        checks++; if (set_done !== 1'b0) $display("FAIL %s set_done_pulse got %0b want 0", tag, set_done); else passed++;
`ifdef HLPTE_MON_CHECKSUM_EN
        checks++; if (out_sum !== 32'd2) $display("FAIL %s out_sum_hold got %0d want 2", tag, out_sum); else passed++;
`endif
        idle(1);
        burst_param(PARAM_BEATS);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 32'd5);
        step(1'b0, 1'b0, 1'b1, 32'd6);
        step(1'b0, 1'b0, 1'b1, 32'd7);
        step(1'b0, 1'b0, 1'b1, 32'd8);
        idle(1);
        checks++; if (set_done !== 1'b1) $display("FAIL %s set_done2 got %0b want 1", tag, set_done); else passed++;
        checks++; if (set_cnt !== 2'd0) $display("FAIL %s set_cnt_wrap got %0d want 0", tag, set_cnt); else passed++;
        checks++; if (pat_cnt !== 16'd1) $display("FAIL %s pat_cnt got %0d want 1", tag, pat_cnt); else passed++;
        checks++; if (total_latency !== 32'd10) $display("FAIL %s total2 got %0d want 10", tag, total_latency); else passed++;
        checks++; if (err_flag !== 1'b0 || err_code !== 4'd0)
            $display("FAIL %s clean_err got flag=%0b code=%0d want 0/0", tag, err_flag, err_code); else passed++;
`ifdef HLPTE_MON_CHECKSUM_EN
        checks++; if (out_sum !== 32'd26) $display("FAIL %s out_sum2 got %0d want 26", tag, out_sum); else passed++;
`endif
    endtask

    task automatic test_full_pattern();
        do_reset();
        run_pattern("full");
    endtask

    task automatic test_short_data();
        do_reset();
        burst_data(DATA_BEATS - 1);
        checks++; if (err_flag !== 1'b0) $display("FAIL short_data_pre got %0b want 0", err_flag); else passed++;
        idle(1);
        checks++; if (err_flag !== 1'b1 || err_code !== 4'd1)
            $display("FAIL short_data got flag=%0b code=%0d want 1/1", err_flag, err_code); else passed++;
    endtask

    task automatic test_gap_errors();
        do_reset();
        burst_data(DATA_BEATS);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (err_code !== 4'd2) $display("FAIL gap_short got %0d want 2", err_code); else passed++;
        do_reset();
        burst_data(DATA_BEATS);
        idle(4);
        checks++; if (err_flag !== 1'b0) $display("FAIL gap_max_ok got %0b want 0", err_flag); else passed++;
        idle(1);
        checks++; if (err_code !== 4'd3) $display("FAIL gap_long got %0d want 3", err_code); else passed++;
    endtask

    task automatic test_wait_errors();
        do_reset();
        burst_data(DATA_BEATS); idle(3); burst_param(PARAM_BEATS);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (err_code !== 4'd5) $display("FAIL wait_param got %0d want 5", err_code); else passed++;
        do_reset();
        burst_data(DATA_BEATS); idle(3); burst_param(PARAM_BEATS);
        idle(MAX_LAT - 1);
        checks++; if (err_flag !== 1'b0) $display("FAIL timeout_early got %0b want 0", err_flag); else passed++;
        idle(1);
        checks++; if (err_code !== 4'd6) $display("FAIL timeout got %0d want 6", err_code); else passed++;
    endtask

    task automatic test_out_errors();
        do_reset();
        burst_data(DATA_BEATS); idle(3); burst_param(PARAM_BEATS); idle(5);
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'd1);
        idle(1);
        checks++; if (err_code !== 4'd7) $display("FAIL out_short got %0d want 7", err_code); else passed++;
        do_reset();
        burst_data(DATA_BEATS); idle(3); burst_param(PARAM_BEATS); idle(5);
        repeat (4) step(1'b0, 1'b0, 1'b1, 32'd1);
        checks++; if (err_flag !== 1'b0) $display("FAIL out_len_ok got %0b want 0", err_flag); else passed++;
        step(1'b0, 1'b0, 1'b1, 32'd1);
        checks++; if (err_code !== 4'd8) $display("FAIL out_long got %0d want 8", err_code); else passed++;
    endtask

    task automatic test_global_and_sticky();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'd0);
        checks++; if (err_code !== 4'd9) $display("FAIL out_in_idle got %0d want 9", err_code); else passed++;
        do_reset();
        step(1'bx, 1'b0, 1'b0, 32'd0);
        checks++; if (err_flag !== 1'b0) $display("FAIL x_valid got %0b want 0", err_flag); else passed++;
        burst_data(DATA_BEATS); idle(1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (err_code !== 4'd10) $display("FAIL data_in_gap got %0d want 10", err_code); else passed++;
        step(1'b0, 1'b0, 1'b1, 32'd0);
        checks++; if (err_flag !== 1'b1 || err_code !== 4'd10)
            $display("FAIL sticky got flag=%0b code=%0d want 1/10", err_flag, err_code); else passed++;
        do_reset();
        burst_data(DATA_BEATS); idle(1);
        step(1'b1, 1'b0, 1'b1, 32'd0);
        checks++; if (err_code !== 4'd9) $display("FAIL multi_lowest got %0d want 9", err_code); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        burst_data(DATA_BEATS); idle(3); burst_param(PARAM_BEATS); idle(5);
        repeat (4) step(1'b0, 1'b0, 1'b1, 32'd1);
        idle(3); burst_param(PARAM_BEATS); idle(5);
        repeat (2) step(1'b0, 1'b0, 1'b1, 32'd1);
        rst_n = 1'b0;
        idle(1);
        checks++; if (set_cnt !== 2'd0 || total_latency !== 32'd0 || set_latency !== 5'd0)
            $display("FAIL mid_reset got set=%0d tot=%0d lat=%0d want 0/0/0", set_cnt, total_latency, set_latency); else passed++;
        checks++; if (err_flag !== 1'b0 || set_done !== 1'b0 || pat_cnt !== 16'd0)
            $display("FAIL mid_reset_flags got err=%0b done=%0b pat=%0d want 0/0/0", err_flag, set_done, pat_cnt); else passed++;
        rst_n = 1'b1;
        run_pattern("after_reset");
    endtask

    initial begin
        checks         = 0;
        passed         = 0;
        rst_n          = 1'b0;
        in_valid_data  = 1'b0;
        in_valid_param = 1'b0;
        out_valid      = 1'b0;
        out_value      = 32'd0;
        test_reset();
        test_full_pattern();
        test_short_data();
        test_gap_errors();
        test_wait_errors();
        test_out_errors();
        test_global_and_sticky();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
